// File: rtl/control_fsm.sv
// Multicycle control unit for the MIPS32 division/sort datapath.
// Sequences IF/ID/EX/MEM/LMD/WB/BR and decodes datapath controls from state and opcode.
module control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_all,
  input  logic             start,
  input  logic [31:0]      out_ins,
  input  logic [2:0]       comp_res,
  output logic             en_ins_mem,
  output logic             load_ir,
  output logic             read,
  output logic             write,
  output logic             en,
  output logic             writeport,
  output logic             writedata,
  output logic             src1,
  output logic             src2,
  output logic             isbranch,
  output logic             selcomp,
  output logic             ld_lmd,
  output logic             en_data_mem,
  output logic             wri_data_mem,
  output logic [4:0]       alu_func,
  output logic [1:0]       selsig,
  output logic             selPC,
  output logic             ld_pc,
  output logic             resetPC,
  output logic             sort_sel,
  output logic [3:0]       location,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StIdle, StIf, StId, StEx, StMem, StLmd, StWb, StBr, StHalt
  } state_e;

  localparam logic [4:0] OpR    = 5'b00000;
  localparam logic [4:0] OpAddi = 5'b00001;
  localparam logic [4:0] OpLd   = 5'b00010;
  localparam logic [4:0] OpSt   = 5'b00011;
  localparam logic [4:0] OpBeq  = 5'b00100;
  localparam logic [4:0] OpBlt  = 5'b00101;
  localparam logic [4:0] OpBgt  = 5'b00110;
  localparam logic [4:0] OpBeqz = 5'b00111;
  localparam logic [4:0] OpJal  = 5'b01000;
  localparam logic [4:0] OpHalt = 5'b11111;

  state_e     state_q;
  logic       start_ok_q;
  logic       retire;
  logic [1:0] br_sel;
  logic [4:0] opcode;

  // Comparator flags are consumed by the datapath PC mux, not by the sequencer.
  logic unused_bits;
  assign unused_bits = ^{comp_res, out_ins[26:5]};

  assign opcode   = out_ins[31:27];
  assign sort_sel = 1'b0;
  assign location = 4'd0;
  assign busy     = (state_q != StIdle) && (state_q != StHalt);
  assign retire   = (state_q == StWb) || (state_q == StBr) ||
                    ((state_q == StMem) && (opcode == OpSt));

  always_ff @(posedge clk or posedge reset_all) begin
    if (reset_all) begin
      state_q     <= StIdle;
      start_ok_q  <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      // Blocks a start sampled on the first edge after reset release.
      start_ok_q <= 1'b1;
      if (retire && (instr_count != '1)) instr_count <= instr_count + 1'b1;
      unique case (state_q)
        StIdle: if (start && start_ok_q) state_q <= StIf;
        StIf:   state_q <= StId;
        StId:   state_q <= StEx;
        StEx: begin
          case (opcode)
            OpR, OpAddi:                       state_q <= StWb;
            OpLd, OpSt:                        state_q <= StMem;
            OpBeq, OpBlt, OpBgt, OpBeqz, OpJal: state_q <= StBr;
            OpHalt: begin
              state_q <= StHalt;
              halted  <= 1'b1;
            end
            default: begin
              state_q <= StHalt;
              halted  <= 1'b1;
              illegal <= 1'b1;
            end
          endcase
        end
        StMem:      state_q <= (opcode == OpLd) ? StLmd : StIf;
        StLmd:      state_q <= StWb;
        StWb, StBr: state_q <= StIf;
        StHalt: begin
          if (start) begin
            state_q <= StIf;
            halted  <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    en_ins_mem   = 1'b0;
    load_ir      = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    en           = 1'b0;
    writeport    = 1'b0;
    writedata    = 1'b0;
    src1         = 1'b0;
    src2         = 1'b0;
    isbranch     = 1'b0;
    selcomp      = 1'b0;
    ld_lmd       = 1'b0;
    en_data_mem  = 1'b0;
    wri_data_mem = 1'b0;
    alu_func     = 5'd0;
    selsig       = 2'b00;
    selPC        = 1'b0;
    ld_pc        = 1'b0;
    resetPC      = 1'b0;
    br_sel       = 2'b00;
    case (opcode)
      OpBeq, OpBeqz: br_sel = 2'b10;
      OpBlt:         br_sel = 2'b01;
      OpBgt:         br_sel = 2'b11;
      default:       br_sel = 2'b00;
    endcase
    unique case (state_q)
      StIdle: resetPC = 1'b1;
      StIf:   en_ins_mem = 1'b1;
      StId: begin
        load_ir = 1'b1;
        read    = 1'b1;
        en      = 1'b1;
      end
      StEx: begin
        case (opcode)
          OpR: begin
            alu_func = out_ins[4:0];
            src1     = 1'b1;
            src2     = 1'b1;
          end
          OpAddi, OpLd, OpSt: src1 = 1'b1;
          OpBeq, OpBlt, OpBgt, OpBeqz: begin
            selsig  = br_sel;
            selcomp = (opcode == OpBeqz);
          end
          default: ;
        endcase
      end
      StMem: begin
        src1        = 1'b1;
        en_data_mem = 1'b1;
        if (opcode == OpSt) begin
          wri_data_mem = 1'b1;
          ld_pc        = 1'b1;
        end
      end
      StLmd: begin
        src1   = 1'b1;
        ld_lmd = 1'b1;
      end
      StWb: begin
        write     = 1'b1;
        en        = 1'b1;
        ld_pc     = 1'b1;
        writeport = (opcode == OpR);
        writedata = (opcode == OpR) || (opcode == OpAddi);
      end
      StBr: begin
        ld_pc = 1'b1;
        if (opcode == OpJal) begin
          selPC    = 1'b1;
          write    = 1'b1;
          en       = 1'b1;
          isbranch = 1'b1;
        end else begin
          selsig  = br_sel;
          selcomp = (opcode == OpBeqz);
        end
      end
      StHalt: resetPC = start;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed-vector bench for control_fsm: per-state control patterns, halts, reset and saturation.
module tb_control_fsm;

  logic        clk;
  logic        reset_all;
  logic        start;
  logic [31:0] out_ins;
  logic [2:0]  comp_res;
  logic        en_ins_mem, load_ir, read, write, en, writeport, writedata, src1, src2;
  logic        isbranch, selcomp, ld_lmd, en_data_mem, wri_data_mem, selPC, ld_pc, resetPC;
  logic        sort_sel, busy, halted, illegal;
  logic [4:0]  alu_func;
  logic [1:0]  selsig;
  logic [3:0]  location;
  logic [15:0] instr_count;

  logic        rst_s, start_s;
  logic        s_eim, s_lir, s_rd, s_wr, s_en, s_wp, s_wd, s_s1, s_s2, s_isb, s_scmp, s_lmd;
  logic        s_edm, s_wdm, s_spc, s_ldpc, s_rpc, s_sort, s_busy, s_halt, s_ill;
  logic [4:0]  s_alu;
  logic [1:0]  s_ss;
  logic [3:0]  s_loc;
  logic [3:0]  s_cnt;

  int          n_cmp;
  int          n_bad;
  logic [15:0] exp_cnt;
  logic [26:0] obs;

  localparam logic [26:0] RPC  = 27'd1 << 0;
  localparam logic [26:0] LDPC = 27'd1 << 1;
  localparam logic [26:0] SPC  = 27'd1 << 2;
  localparam logic [26:0] SS01 = 27'd1 << 3;
  localparam logic [26:0] SS10 = 27'd2 << 3;
  localparam logic [26:0] SS11 = 27'd3 << 3;
  localparam logic [26:0] WDM  = 27'd1 << 10;
  localparam logic [26:0] EDM  = 27'd1 << 11;
  localparam logic [26:0] LLMD = 27'd1 << 12;
  localparam logic [26:0] SCMP = 27'd1 << 13;
  localparam logic [26:0] ISB  = 27'd1 << 14;
  localparam logic [26:0] S2   = 27'd1 << 15;
  localparam logic [26:0] S1   = 27'd1 << 16;
  localparam logic [26:0] WD   = 27'd1 << 17;
  localparam logic [26:0] WP   = 27'd1 << 18;
  localparam logic [26:0] EN   = 27'd1 << 19;
  localparam logic [26:0] WR   = 27'd1 << 20;
  localparam logic [26:0] RD   = 27'd1 << 21;
  localparam logic [26:0] LIR  = 27'd1 << 22;
  localparam logic [26:0] EIM  = 27'd1 << 23;
  localparam logic [26:0] ILL  = 27'd1 << 24;
  localparam logic [26:0] HLT  = 27'd1 << 25;
  localparam logic [26:0] BSY  = 27'd1 << 26;

  localparam logic [26:0] E_IF = BSY | EIM;
  localparam logic [26:0] E_ID = BSY | LIR | RD | EN;

  assign obs = {busy, halted, illegal, en_ins_mem, load_ir, read, write, en, writeport,
                writedata, src1, src2, isbranch, selcomp, ld_lmd, en_data_mem, wri_data_mem,
                alu_func, selsig, selPC, ld_pc, resetPC};

  control_fsm #(.CNT_W(16)) dut (
    .clk(clk), .reset_all(reset_all), .start(start), .out_ins(out_ins), .comp_res(comp_res),
    .en_ins_mem(en_ins_mem), .load_ir(load_ir), .read(read), .write(write), .en(en),
    .writeport(writeport), .writedata(writedata), .src1(src1), .src2(src2),
    .isbranch(isbranch), .selcomp(selcomp), .ld_lmd(ld_lmd), .en_data_mem(en_data_mem),
    .wri_data_mem(wri_data_mem), .alu_func(alu_func), .selsig(selsig), .selPC(selPC),
    .ld_pc(ld_pc), .resetPC(resetPC), .sort_sel(sort_sel), .location(location),
    .busy(busy), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  // Narrow counter instance running back-to-back stores.
  control_fsm #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset_all(rst_s), .start(start_s), .out_ins(32'h1800_0000),
    .comp_res(3'b000),
    .en_ins_mem(s_eim), .load_ir(s_lir), .read(s_rd), .write(s_wr), .en(s_en),
    .writeport(s_wp), .writedata(s_wd), .src1(s_s1), .src2(s_s2),
    .isbranch(s_isb), .selcomp(s_scmp), .ld_lmd(s_lmd), .en_data_mem(s_edm),
    .wri_data_mem(s_wdm), .alu_func(s_alu), .selsig(s_ss), .selPC(s_spc),
    .ld_pc(s_ldpc), .resetPC(s_rpc), .sort_sel(s_sort), .location(s_loc),
    .busy(s_busy), .halted(s_halt), .illegal(s_ill), .instr_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if (obs !== RPC) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required %h", obs, RPC);
    end
    n_cmp++;
    if (instr_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_count: got %h required 0000", instr_count);
    end
    n_cmp++;
    if ({sort_sel, location} !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_sort_loc: got %h required 00", {sort_sel, location});
    end
  endtask

  task automatic test_start_sync();
    @(negedge clk);
    reset_all = 1'b0;
    start     = 1'b1;
    out_ins   = 32'h0000_0000;
    tick();
    n_cmp++;
    if (obs !== RPC) begin
      n_bad++;
      $display("FAIL start_at_release: got %h required %h", obs, RPC);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic test_r_type(input logic [4:0] f);
    logic [26:0] e [4];
    out_ins = {27'd0, f};
    e = '{E_IF, E_ID, BSY | S1 | S2 | (27'(f) << 5), BSY | WR | EN | WP | WD | LDPC};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL r_type f=%0d step %0d: got %h required %h", f, i, obs, e[i]);
      end
      tick();
    end
    exp_cnt++;
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL r_type_count: got %h required %h", instr_count, exp_cnt);
    end
  endtask

  task automatic test_addi_busy_start();
    logic [26:0] e [4];
    out_ins = 32'h0800_0000;
    start   = 1'b1;
    e = '{E_IF, E_ID, BSY | S1, BSY | WR | EN | WD | LDPC};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL addi step %0d: got %h required %h", i, obs, e[i]);
      end
      tick();
    end
    start = 1'b0;
    exp_cnt++;
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL addi_count: got %h required %h", instr_count, exp_cnt);
    end
  endtask

  task automatic test_ld();
    logic [26:0] e [6];
    out_ins = 32'h1000_0000;
    e = '{E_IF, E_ID, BSY | S1, BSY | S1 | EDM, BSY | S1 | LLMD, BSY | WR | EN | LDPC};
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL ld step %0d: got %h required %h", i, obs, e[i]);
      end
      tick();
    end
    exp_cnt++;
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL ld_count: got %h required %h", instr_count, exp_cnt);
    end
  endtask

  task automatic test_st();
    logic [26:0] e [4];
    out_ins = 32'h1800_0000;
    e = '{E_IF, E_ID, BSY | S1, BSY | S1 | EDM | WDM | LDPC};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL st step %0d: got %h required %h", i, obs, e[i]);
      end
      tick();
    end
    exp_cnt++;
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL st_count: got %h required %h", instr_count, exp_cnt);
    end
  endtask

  task automatic test_branch(input logic [4:0] op, input logic [26:0] sel,
                             input logic [2:0] cmp);
    logic [26:0] e [4];
    out_ins  = {op, 27'd0};
    comp_res = cmp;
    e = '{E_IF, E_ID, BSY | sel, BSY | sel | LDPC};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL branch op=%b cmp=%b step %0d: got %h required %h",
                 op, cmp, i, obs, e[i]);
      end
      tick();
    end
    exp_cnt++;
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL branch_count op=%b: got %h required %h", op, instr_count, exp_cnt);
    end
  endtask

  task automatic test_jal();
    logic [26:0] e [4];
    out_ins = 32'h4000_0000;
    e = '{E_IF, E_ID, BSY, BSY | LDPC | SPC | WR | EN | ISB};
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL jal step %0d: got %h required %h", i, obs, e[i]);
      end
      tick();
    end
    exp_cnt++;
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL jal_count: got %h required %h", instr_count, exp_cnt);
    end
  endtask

  task automatic test_halt(input logic [31:0] ins, input logic [26:0] flags);
    logic [26:0] e [5];
    out_ins = ins;
    e = '{E_IF, E_ID, BSY, flags, flags};
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (obs !== e[i]) begin
        n_bad++;
        $display("FAIL halt op=%b step %0d: got %h required %h", ins[31:27], i, obs, e[i]);
      end
      if (i < 4) tick();
    end
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL halt_count: got %h required %h", instr_count, exp_cnt);
    end
    start = 1'b1;
    #1;
    n_cmp++;
    if (obs !== (flags | RPC)) begin
      n_bad++;
      $display("FAIL halt_restart_pc: got %h required %h", obs, flags | RPC);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (obs !== E_IF) begin
      n_bad++;
      $display("FAIL halt_resume_if: got %h required %h", obs, E_IF);
    end
  endtask

  task automatic test_reset_mid_ld();
    out_ins = 32'h1000_0000;
    repeat (4) tick();
    n_cmp++;
    if (obs !== (BSY | S1 | LLMD)) begin
      n_bad++;
      $display("FAIL abort_in_lmd: got %h required %h", obs, BSY | S1 | LLMD);
    end
    #2;
    reset_all = 1'b1;
    #1;
    exp_cnt = 16'd0;
    n_cmp++;
    if (obs !== RPC) begin
      n_bad++;
      $display("FAIL abort_async_outputs: got %h required %h", obs, RPC);
    end
    n_cmp++;
    if (instr_count !== exp_cnt) begin
      n_bad++;
      $display("FAIL abort_count: got %h required %h", instr_count, exp_cnt);
    end
    tick();
    n_cmp++;
    if ((write !== 1'b0) || (ld_pc !== 1'b0)) begin
      n_bad++;
      $display("FAIL abort_no_wb: got write=%b ld_pc=%b required 0 0", write, ld_pc);
    end
    @(negedge clk);
    reset_all = 1'b0;
  endtask

  task automatic test_saturation();
    logic [3:0] e_cnt;
    @(negedge clk);
    rst_s = 1'b0;
    tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 20; i++) begin
      repeat (4) tick();
      e_cnt = (i >= 14) ? 4'hF : 4'(i + 1);
      n_cmp++;
      if (s_cnt !== e_cnt) begin
        n_bad++;
        $display("FAIL saturation after %0d stores: got %h required %h", i + 1, s_cnt, e_cnt);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    exp_cnt   = 16'd0;
    reset_all = 1'b1;
    rst_s     = 1'b1;
    start     = 1'b0;
    start_s   = 1'b0;
    out_ins   = 32'h0000_0000;
    comp_res  = 3'b000;
    test_reset();
    test_start_sync();
    test_r_type(5'd0);
    test_r_type(5'd3);
    test_addi_busy_start();
    test_ld();
    test_st();
    test_branch(5'b00100, SS10, 3'b010);
    test_branch(5'b00100, SS10, 3'b100);
    test_branch(5'b00101, SS01, 3'b001);
    test_branch(5'b00110, SS11, 3'b100);
    test_branch(5'b00111, SS10 | SCMP, 3'b010);
    test_jal();
    test_halt(32'hF800_0000, HLT);
    test_halt(32'hA800_0000, HLT | ILL);
    test_reset_mid_ld();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
